// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-input multiplexer.
//   - sel_w():        select width for a given input count, never below 1 bit
//   - NUM_IN_MIN/MAX: legal range of the NUM_IN parameter
//   - count_t, CNT_*: occupancy encoding of the two-entry skid buffer
package mux_pkg;

    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;

    typedef logic [1:0] count_t;

    localparam count_t CNT_EMPTY = 2'd0;
    localparam count_t CNT_ONE   = 2'd1;
    localparam count_t CNT_FULL  = 2'd2;

    // max(1, clog2(n))
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-to-1 word selector.
// Ports:
//   In           NUM_IN*WIDTH packed words, word k at [k*WIDTH +: WIDTH]
//   S            select index
//   Word         selected word, all-zeros when S >= NUM_IN
//   Out_of_range 1 when S >= NUM_IN
module mux_n_sel
    import mux_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    localparam int SEL_W = sel_w(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]        S,
    output logic [WIDTH-1:0]        Word,
    output logic                    Out_of_range
);

    assign Out_of_range = (int'(S) >= NUM_IN);

    // Loop over legal indices only, so an out-of-range select never
    // forms a part-select beyond the bus and falls through to zero.
    always_comb begin
        Word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(S) == k) begin
                Word = In[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input multiplexer with a registered two-entry skid buffer on its output.
// A word is selected from In by S on push (In_valid && In_ready) and
// presented on Result one cycle later; entries leave in FIFO order on pop
// (Out_valid && Out_ready).
// Ports:
//   CLK        clock, rising edge
//   Reset_n    synchronous active-low reset
//   In, S      packed data inputs and select, sampled on push
//   In_valid   producer offers In/S
//   In_ready   buffer has room (count < 2); low while in reset
//   Result     selected word of the head entry (registered)
//   Out_valid  head entry is valid
//   Out_ready  consumer takes the head entry
//   Sel_err    head entry was captured with S >= NUM_IN
// Build option: define MUX_N_PIPE_SELERR_EN to store and report a select
// error bit per entry; otherwise Sel_err is tied to 0.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    localparam int SEL_W = sel_w(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    Reset_n,
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]        S,
    input  logic                    In_valid,
    output logic                    In_ready,
    output logic [WIDTH-1:0]        Result,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic                    Sel_err
);

    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_num_in_check
        $error("mux_n_pipe: NUM_IN outside legal range");
    end

    logic [WIDTH-1:0] sel_word;
    logic             sel_oor;

    mux_n_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .In           (In),
        .S            (S),
        .Word         (sel_word),
        .Out_of_range (sel_oor)
    );

    count_t           count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    logic push, pop;
    logic load_head, load_tail, shift;

    // Ready depends only on registered state and reset, never on Out_ready.
    assign In_ready  = Reset_n && (count_q < CNT_FULL);
    assign Out_valid = (count_q != CNT_EMPTY);
    assign Result    = head_q;

    assign push = In_valid && In_ready;
    assign pop  = Out_valid && Out_ready;

    // New word goes to the head when the head is free or being vacated in
    // the same cycle; otherwise it waits in the tail.
    assign load_head = push && ((count_q == CNT_EMPTY) || ((count_q == CNT_ONE) && pop));
    assign load_tail = push && (count_q == CNT_ONE) && !pop;
    assign shift     = pop && (count_q == CNT_FULL);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;

        case (count_q)
            CNT_EMPTY: if (push) count_d = CNT_ONE;
            CNT_ONE: begin
                if (push && !pop) begin
                    count_d = CNT_FULL;
                end else if (pop && !push) begin
                    count_d = CNT_EMPTY;
                end
            end
            CNT_FULL:  if (pop) count_d = CNT_ONE;
            default:   count_d = CNT_EMPTY;
        endcase

        if (load_head) begin
            head_d = sel_word;
        end else if (shift) begin
            head_d = tail_q;
        end
        if (load_tail) begin
            tail_d = sel_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            count_q <= CNT_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef MUX_N_PIPE_SELERR_EN
    logic head_err_q, tail_err_q;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            head_err_q <= 1'b0;
            tail_err_q <= 1'b0;
        end else begin
            if (load_head) begin
                head_err_q <= sel_oor;
            end else if (shift) begin
                head_err_q <= tail_err_q;
            end
            if (load_tail) begin
                tail_err_q <= sel_oor;
            end
        end
    end

    assign Sel_err = head_err_q;
`else
    logic unused_sel_oor;
    assign unused_sel_oor = sel_oor;
    assign Sel_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: two instances (NUM_IN=4 and NUM_IN=3) share one
// handshake stream, so both buffers hold the same number of entries and a
// single queue of expected entries models them both.
module tb_mux_n_pipe;

    localparam int WIDTH = 16;

`ifdef MUX_N_PIPE_SELERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [WIDTH-1:0] in_words [4];
    logic [63:0]      in_a;
    logic [47:0]      in_b;
    logic [1:0]       s;
    logic             in_valid;
    logic             out_ready;

    logic             a_in_ready, a_out_valid, a_sel_err;
    logic [WIDTH-1:0] a_result;
    logic             b_in_ready, b_out_valid, b_sel_err;
    logic [WIDTH-1:0] b_result;

    assign in_a = {in_words[3], in_words[2], in_words[1], in_words[0]};
    assign in_b = in_a[47:0];

    mux_n_pipe #(
        .WIDTH  (WIDTH),
        .NUM_IN (4)
    ) dut_a (
        .CLK       (clk),
        .Reset_n   (rst_n),
        .In        (in_a),
        .S         (s),
        .In_valid  (in_valid),
        .In_ready  (a_in_ready),
        .Result    (a_result),
        .Out_valid (a_out_valid),
        .Out_ready (out_ready),
        .Sel_err   (a_sel_err)
    );

    mux_n_pipe #(
        .WIDTH  (WIDTH),
        .NUM_IN (3)
    ) dut_b (
        .CLK       (clk),
        .Reset_n   (rst_n),
        .In        (in_b),
        .S         (s),
        .In_valid  (in_valid),
        .In_ready  (b_in_ready),
        .Result    (b_result),
        .Out_valid (b_out_valid),
        .Out_ready (out_ready),
        .Sel_err   (b_sel_err)
    );

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             b_err;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   dut_pushes = 0;
    int   dut_pops = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic verify();
        check1("a_in_ready", a_in_ready, rst_n && (q.size() < 2));
        check1("b_in_ready", b_in_ready, rst_n && (q.size() < 2));
        check1("a_out_valid", a_out_valid, q.size() != 0);
        check1("b_out_valid", b_out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check16("a_result", a_result, q[0].a);
            check16("b_result", b_result, q[0].b);
            check1("a_sel_err", a_sel_err, 1'b0);
            check1("b_sel_err", b_sel_err, ErrEn ? q[0].b_err : 1'b0);
        end
    endtask

    // One clock: predict the handshake from the model, advance it at the
    // edge, then compare all outputs 1 time unit later.
    task automatic cycle();
        bit   push, pop;
        ent_t e;
        push    = in_valid && rst_n && (q.size() < 2);
        pop     = out_ready && rst_n && (q.size() > 0);
        e.a     = in_words[s];
        e.b     = (s < 2'd3) ? in_words[s] : '0;
        e.b_err = (s >= 2'd3);
        if (rst_n && in_valid && a_in_ready) dut_pushes++;
        if (rst_n && out_ready && a_out_valid) dut_pops++;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        #1;
        verify();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = 2'd0;
        for (int i = 0; i < 4; i++) in_words[i] = '0;

        // Reset state and release
        cycle();
        check1("rst_in_ready", a_in_ready, 1'b0);
        check1("rst_out_valid", a_out_valid, 1'b0);
        check16("rst_result", a_result, 16'h0000);
        check1("rst_sel_err", b_sel_err, 1'b0);
        rst_n = 1'b1;
        #1;
        check1("release_in_ready", a_in_ready, 1'b1);

        // Single push, select 2
        in_words[3] = 16'h4444;
        in_words[2] = 16'h3333;
        in_words[1] = 16'h2222;
        in_words[0] = 16'h1111;
        s        = 2'd2;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check1("t30_out_valid", a_out_valid, 1'b1);
        check16("t30_result", a_result, 16'h3333);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Fill with S=0 then S=3, extra push while full is ignored
        in_valid = 1'b1;
        s = 2'd0;
        cycle();
        s = 2'd3;
        cycle();
        check1("t31_full_in_ready", a_in_ready, 1'b0);
        s = 2'd1;
        cycle();
        check16("t31_hold_result", a_result, 16'h1111);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        check16("t31_second_result", a_result, 16'h4444);
        check16("t33_oor_result", b_result, 16'h0000);
        check1("t33_sel_err", b_sel_err, ErrEn);
        cycle();
        check1("t31_drained", a_out_valid, 1'b0);
        out_ready = 1'b0;

        // Push and pop together at count 1
        in_valid = 1'b1;
        s = 2'd0;
        cycle();
        s = 2'd1;
        out_ready = 1'b1;
        cycle();
        check1("t32_out_valid", a_out_valid, 1'b1);
        check1("t32_in_ready", a_in_ready, 1'b1);
        check16("t32_result", a_result, 16'h2222);
        in_valid = 1'b0;
        cycle();
        check1("t32_drained", a_out_valid, 1'b0);
        out_ready = 1'b0;

        // Reset while full, with push and pop requested
        in_valid = 1'b1;
        s = 2'd2;
        cycle();
        cycle();
        check1("t34_full", a_in_ready, 1'b0);
        rst_n = 1'b0;
        out_ready = 1'b1;
        cycle();
        check1("t34_rst_in_ready", a_in_ready, 1'b0);
        check1("t34_rst_out_valid", a_out_valid, 1'b0);
        check16("t34_rst_result_a", a_result, 16'h0000);
        check16("t34_rst_result_b", b_result, 16'h0000);
        check1("t34_rst_sel_err", b_sel_err, 1'b0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check1("t34_release_in_ready", a_in_ready, 1'b1);
        cycle();

        // Random traffic against the queue model
        dut_pushes = 0;
        dut_pops   = 0;
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            s         = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) in_words[i] = 16'($urandom);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        check1("rand_drained", a_out_valid, 1'b0);
        check_int("rand_push_pop_balance", dut_pops, dut_pushes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
